// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed seven-segment driver: hex glyph table,
// blank pattern and a counter-width helper.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Glyphs in {a,b,c,d,e,f,g} order, indexed by nibble value
    localparam logic [6:0] SEG_LUT [0:15] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47
    };

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble to seven-segment decode (active-high, a..g order).
module hex_to_seg7
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_LUT[nib];

endmodule

// File: rtl/seg_scan_driver.sv
// N-digit multiplexed seven-segment driver with double-buffered digits,
// leading-zero suppression and selectable output polarity.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NDIGIT     = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*NDIGIT-1:0]   din,
    input  logic [NDIGIT-1:0]     dp_in,
    input  logic                  lz_en,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NDIGIT-1:0]     dsel,
    output logic                  frame
);

    localparam int   IW  = idx_w(NDIGIT);
    localparam int   PW  = idx_w(SCAN_DIV);
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [PW-1:0]         pcnt;
    logic [IW-1:0]         idx;
    logic                  pending;
    logic [4*NDIGIT-1:0]   shd_dig, dsp_dig;
    logic [NDIGIT-1:0]     shd_dp, dsp_dp;
    logic                  tc, fb;

    assign tc = (pcnt == PW'(SCAN_DIV - 1));
    assign fb = tc && (idx == IW'(NDIGIT - 1));

    // ---- stage p0: scan timing and double buffer ----
    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt    <= '0;
            idx     <= '0;
            pending <= 1'b0;
            shd_dig <= '0;
            shd_dp  <= '0;
            dsp_dig <= '0;
            dsp_dp  <= '0;
        end else begin
            pcnt <= tc ? '0 : pcnt + PW'(1);
            if (tc)
                idx <= (idx == IW'(NDIGIT - 1)) ? '0 : idx + IW'(1);

            // A load landing on the boundary bypasses the shadow so it is not lost
            if (load && fb) begin
                shd_dig <= din;
                shd_dp  <= dp_in;
                dsp_dig <= din;
                dsp_dp  <= dp_in;
                pending <= 1'b0;
            end else if (load) begin
                shd_dig <= din;
                shd_dp  <= dp_in;
                pending <= 1'b1;
            end else if (fb && pending) begin
                dsp_dig <= shd_dig;
                dsp_dp  <= shd_dp;
                pending <= 1'b0;
            end
        end
    end

    logic [NDIGIT-1:0] lz_blank;
    logic              zero_run;
    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_blank;
    logic [NDIGIT-1:0] dsel_n;
    logic [6:0]        dec_seg;
    logic [6:0]        seg_n;

    always_comb begin
        zero_run  = 1'b1;
        lz_blank  = '0;
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        dsel_n    = '0;
        // Walk down from the top digit; a digit is blankable while all above are zero
        for (int i = NDIGIT - 1; i >= 1; i--) begin
            zero_run    = zero_run && (dsp_dig[i*4 +: 4] == 4'h0);
            lz_blank[i] = zero_run;
        end
        for (int i = 0; i < NDIGIT; i++) begin
            if (idx == IW'(i)) begin
                cur_nib   = dsp_dig[i*4 +: 4];
                cur_dp    = dsp_dp[i];
                cur_blank = lz_en && lz_blank[i];
                dsel_n[i] = 1'b1;
            end
        end
    end

    hex_to_seg7 u_dec (
        .nib (cur_nib),
        .seg (dec_seg)
    );

    assign seg_n = cur_blank ? SEG_BLANK : dec_seg;

    logic [6:0]        seg_p1;
    logic              dp_p1;
    logic [NDIGIT-1:0] dsel_p1;
    logic              frame_p1;

    // ---- stage p1: registered outputs with polarity applied ----
    always_ff @(posedge clk) begin
        if (rst) begin
            seg_p1   <= {7{POL}};
            dp_p1    <= POL;
            dsel_p1  <= {NDIGIT{POL}};
            frame_p1 <= 1'b0;
        end else begin
            seg_p1   <= seg_n ^ {7{POL}};
            dp_p1    <= cur_dp ^ POL;
            dsel_p1  <= dsel_n ^ {NDIGIT{POL}};
            frame_p1 <= fb;
        end
    end

    assign seg   = seg_p1;
    assign dp    = dp_p1;
    assign dsel  = dsel_p1;
    assign frame = frame_p1;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: one active-high and one active-low
// instance share stimulus; a timing model predicts every output cycle.
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [15:0]   din;
    logic [3:0]    dp_in;
    logic          lz_en;
    logic [6:0]    seg0, seg1;
    logic          dp0, dp1;
    logic [3:0]    dsel0, dsel1;
    logic          frame0, frame1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    seg_scan_driver #(.NDIGIT(ND), .SCAN_DIV(SD), .ACTIVE_LOW(0)) u_hi (
        .clk(clk), .rst(rst), .load(load), .din(din), .dp_in(dp_in), .lz_en(lz_en),
        .seg(seg0), .dp(dp0), .dsel(dsel0), .frame(frame0)
    );

    seg_scan_driver #(.NDIGIT(ND), .SCAN_DIV(SD), .ACTIVE_LOW(1)) u_lo (
        .clk(clk), .rst(rst), .load(load), .din(din), .dp_in(dp_in), .lz_en(lz_en),
        .seg(seg1), .dp(dp1), .dsel(dsel1), .frame(frame1)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'h7E;  4'h1: return 7'h30;  4'h2: return 7'h6D;  4'h3: return 7'h79;
            4'h4: return 7'h33;  4'h5: return 7'h5B;  4'h6: return 7'h5F;  4'h7: return 7'h70;
            4'h8: return 7'h7F;  4'h9: return 7'h7B;  4'hA: return 7'h77;  4'hB: return 7'h1F;
            4'hC: return 7'h4E;  4'hD: return 7'h3D;  4'hE: return 7'h4F;  default: return 7'h47;
        endcase
    endfunction

    // Model: position derived from cycles elapsed since reset release
    logic [12:0] q[$];
    int          m_t, m_d;
    logic        m_pend, m_bnd;
    logic [15:0] m_shd, m_dsp;
    logic [3:0]  m_shdp, m_dspp;
    logic [6:0]  m_seg;

    always @(posedge clk) begin
        if (rst) begin
            m_t = 0; m_pend = 1'b0;
            m_shd = '0; m_shdp = '0; m_dsp = '0; m_dspp = '0;
            q.push_back(13'h0);
        end else begin
            m_d   = (m_t / SD) % ND;
            m_bnd = ((m_t % (ND * SD)) == (ND * SD - 1));
            m_seg = glyph(m_dsp[4*m_d +: 4]);
            if (lz_en && m_d > 0 && (m_dsp >> (4 * m_d)) == 16'h0)
                m_seg = 7'h00;
            q.push_back({m_bnd, m_dspp[m_d], 4'(4'b0001 << m_d), m_seg});
            if (load) begin
                if (m_bnd) begin
                    m_dsp = din; m_dspp = dp_in; m_pend = 1'b0;
                end else begin
                    m_shd = din; m_shdp = dp_in; m_pend = 1'b1;
                end
            end else if (m_bnd && m_pend) begin
                m_dsp = m_shd; m_dspp = m_shdp; m_pend = 1'b0;
            end
            m_t++;
        end
    end

    logic [12:0] e;
    logic [6:0]  e_seg_n;
    logic [3:0]  e_dsel_n;
    logic        e_dp_n;

    always @(negedge clk) begin
        if (q.size() > 0) begin
            e        = q.pop_front();
            e_seg_n  = ~e[6:0];
            e_dsel_n = ~e[10:7];
            e_dp_n   = ~e[11];
            check_val("seg",      seg0,   e[6:0]);
            check_val("dsel",     dsel0,  e[10:7]);
            check_val("dp",       dp0,    e[11]);
            check_val("frame",    frame0, e[12]);
            check_val("seg_al",   seg1,   e_seg_n);
            check_val("dsel_al",  dsel1,  e_dsel_n);
            check_val("dp_al",    dp1,    e_dp_n);
            check_val("frame_al", frame1, e[12]);
        end
    end

    task automatic do_load(input logic [15:0] d, input logic [3:0] p);
        @(negedge clk);
        din = d; dp_in = p; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (frame0) break;
        end
        check_val("frame_seen", frame0, 1'b1);
    endtask

    // Checks one full frame starting at the negedge after the frame pulse
    task automatic sweep(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                         input logic [6:0] e2, input logic [6:0] e3);
        logic [6:0] ev [4];
        logic [3:0] sel;
        ev[0] = e0; ev[1] = e1; ev[2] = e2; ev[3] = e3;
        for (int k = 0; k < ND; k++) begin
            sel = 4'(4'b0001 << k);
            for (int c = 0; c < SD; c++) begin
                @(negedge clk);
                check_val({tag, "_seg"},  seg0,  ev[k]);
                check_val({tag, "_dsel"}, dsel0, sel);
            end
        end
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; din = '0; dp_in = '0; lz_en = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_seg_al",  seg1,  7'h7F);
        check_val("rst_dsel_al", dsel1, 4'hF);
        rst = 1'b0;
        @(negedge clk);
        check_val("first_seg",  seg0,  7'h7E);
        check_val("first_dsel", dsel0, 4'b0001);

        do_load(16'h0123, 4'b0000);
        wait_frame();
        sweep("decode", 7'h79, 7'h6D, 7'h30, 7'h7E);

        lz_en = 1'b1;
        wait_frame();
        sweep("lz", 7'h79, 7'h6D, 7'h30, 7'h00);
        do_load(16'h0000, 4'b0000);
        wait_frame();
        sweep("lz0", 7'h7E, 7'h00, 7'h00, 7'h00);

        lz_en = 1'b0;
        wait_frame();
        repeat (5) @(negedge clk);
        do_load(16'hABCD, 4'b0000);
        repeat (3) @(negedge clk);
        do_load(16'hEF01, 4'b0000);
        wait_frame();
        sweep("coh", 7'h30, 7'h7E, 7'h47, 7'h4F);

        wait_frame();
        repeat (15) @(negedge clk);
        din = 16'h4567; dp_in = 4'b0000; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check_val("sim_frame", frame0, 1'b1);
        @(negedge clk);
        check_val("sim_seg",  seg0,  7'h70);
        check_val("sim_dsel", dsel0, 4'b0001);

        do_load(16'h0008, 4'b0001);
        wait_frame();
        @(negedge clk);
        check_val("pol_seg",  seg1,  7'h00);
        check_val("pol_dp",   dp1,   1'b0);
        check_val("pol_dsel", dsel1, 4'b1110);
        repeat (4) @(negedge clk);
        check_val("pol_dp1",  dp1,   1'b1);

        wait_frame();
        repeat (2) @(negedge clk);
        do_load(16'h9999, 4'b1111);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_val("mid_rst_seg",   seg0,   7'h00);
        check_val("mid_rst_dsel",  dsel0,  4'b0000);
        check_val("mid_rst_frame", frame0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        wait_frame();
        sweep("post_rst", 7'h7E, 7'h7E, 7'h7E, 7'h7E);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Multiplexed N-digit seven-segment display driver. It generalises the single-digit 4-bit binary-to-segment decoder. A bank of NDIGIT hex nibbles is double-buffered, and one digit at a time is scanned out on a shared segment bus at a parametrised refresh rate. Leading-zero suppression, decimal points and selectable output polarity are included. It sits between a lab datapath (counter, ALU result) and the board's common-anode or common-cathode display.

## Interface
Parameters:
- NDIGIT, 4, number of digits scanned (1..8)
- SCAN_DIV, 1000, clock cycles each digit is held active (≥2)
- ACTIVE_LOW, 0, 1 = invert seg, dp and dsel outputs (common-anode board)

Ports:
- clk  in  1  system clock; single clock domain
- rst  in  1  synchronous, active-high reset
- load  in  1  one-cycle strobe: capture din/dp_in into shadow buffer
- din  in  4*NDIGIT  hex digits; din[3:0] = digit 0 (rightmost, least significant)
- dp_in  in  NDIGIT  decimal point per digit
- lz_en  in  1  leading-zero suppression enable (sampled live)
- seg  out  7  segments, seg[6]=a … seg[0]=g
- dp  out  1  decimal point of active digit
- dsel  out  NDIGIT  one-hot digit enable
- frame  out  1  one-cycle pulse at each frame boundary

## Operation
- **Prescaler.** pcnt counts 0..SCAN_DIV-1 and wraps.
  - tc = (pcnt == SCAN_DIV-1).
  - On tc, the digit index idx advances 0→1→…→NDIGIT-1→0.
- **Frame boundary.** Occurs on the tc cycle with idx == NDIGIT-1.
  - frame asserts on the following cycle, for one cycle.
- **Double buffer.** There is a shadow register (digits + dp) and a display register.
  - load=1: shadow ← din/dp_in, and pending ← 1.
  - A repeated load while pending overwrites the shadow (last wins).
  - At a frame boundary with pending=1: display ← shadow, pending ← 0.
  - load on the same cycle as a frame boundary: display ← din/dp_in directly, pending stays 0.
  - The display contents therefore never change mid-frame.
- **Decode.** Fixed hex LUT, shown as {a..g}:
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47
- **Leading-zero suppression.** With lz_en=1, digit i (i>0) is blanked (seg=00) when it and every higher digit of the display register are 0.
  - Digit 0 is never blanked.
  - dp is unaffected by suppression.
- **Polarity.** Internal logic is active-high. With ACTIVE_LOW=1, seg, dp and dsel are bitwise inverted at the output registers.
- **Reset.** Clears pcnt, idx, pending, the shadow and the display register.

## Timing
- seg, dp, dsel and frame are registered.
- They reflect idx with 1-cycle latency: dsel changes on the cycle after tc.
- Reset values (logical, before polarity inversion):
  - seg=0000000, dp=0, dsel=0, frame=0.
  - With ACTIVE_LOW=1: seg=7F, dp=1, dsel all ones.
- First cycle after rst deasserts: outputs drive digit 0 of the cleared display.
  - seg = 7E (digit 0 is never suppressed), dsel = 0…01.
- Digit dwell: exactly SCAN_DIV cycles. Frame period: NDIGIT·SCAN_DIV cycles.
- Load-to-visible latency: until the next frame boundary, worst case NDIGIT·SCAN_DIV cycles.
- rst mid-frame: everything returns to reset values on the next edge, and any pending load is discarded.
- NDIGIT=1: idx stays 0, and every tc is a frame boundary.

## Structure
- Package seg_pkg holds:
  - the 16-entry SEG_LUT constant (7-bit, a..g order);
  - the blank constant SEG_BLANK = 7'h00;
  - a clog2-based index width helper.
- Sub-module hex_to_seg7 is a combinational nibble→7-bit decode using SEG_LUT, instantiated once on the muxed digit.
- The top holds the prescaler, index counter, double buffer, suppression logic and output registers.

## Test plan
- **Reset/decode sweep.** NDIGIT=4, SCAN_DIV=4, ACTIVE_LOW=0. Load din=16'h0123 and wait one frame.
  - dsel cycles 0001→0010→0100→1000, each held 4 cycles.
  - seg = 79, 6D, 30, 7E respectively.
- **Leading-zero suppression.** Same load with lz_en=1.
  - Digit 3 shows seg=00; digits 0..2 unchanged.
  - Load 16'h0000: only digit 0 shows 7E.
- **Buffer coherency.** Load 16'hABCD mid-frame, then 16'hEF01 before the boundary.
  - The current frame keeps the old value.
  - The next frame shows the digits 1,0,F,E (digit 0 first) = 30, 7E, 47, 4F.
  - ABCD never appears.
- **Simultaneous load and boundary.** Pulse load on the tc cycle of digit 3.
  - The next frame shows the new value immediately.
  - pending=0 afterwards.
- **Polarity and dp.** ACTIVE_LOW=1, load digit 0 = 8 with dp_in=0001.
  - At digit 0: seg=00, dp=0, dsel=1110.
  - Other digits: dp=1.
- **Reset mid-operation.** Pending load plus rst in the middle of digit 2.
  - Outputs return to reset values and frame=0.
  - The pending value is never displayed.
